// File: rtl/apb_reg_bank_if.sv
// APB3 bus bundle between the system bus master and the watermark register bank.
interface apb_reg_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_bank.sv
// APB3 slave holding watermark-engine configuration and pixel memory, with
// wait-state control, start/done/irq handshake and a private engine read port.
module apb_reg_bank #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    apb_reg_bank_if.slave     apb,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              eng_busy,
    input  logic              eng_done,
    output logic              start,
    output logic              irq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NCFG  = 10;

    // The SETUP phase is recognised combinationally while IDLE (psel & ~penable);
    // the register only has to remember that an ACCESS phase is under way.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, next_state;
    logic [3:0]        cnt, next_cnt;
    logic              pready_q, pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic              done, ie;
    logic [DATA_W-1:0] cfg [1:NCFG-1];
    logic [DATA_W-1:0] pix [0:DEPTH-1];

    logic in_range, err_d, fin_d;
    logic wr_fire, wr_ctrl, wr_cfg, wr_pix;

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a >= ADDR_W'(DEPTH))
            v = '0;
        else if (a == '0)
            v = DATA_W'({ie, done, eng_busy, 1'b0});
        else if (a < ADDR_W'(NCFG))
            v = cfg[a[3:0]];
        else
            v = pix[a[IDX_W-1:0]];
        return v;
    endfunction

    assign in_range = apb.paddr < ADDR_W'(DEPTH);
    assign err_d    = ~in_range | (apb.pwrite & (apb.paddr != '0) & eng_busy);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    next_state = ACCESS;
                    next_cnt   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!apb.psel || cnt == 4'd0)
                    next_state = IDLE;
                else
                    next_cnt = cnt - 4'd1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so the completing cycle is decided one edge early.
    assign fin_d = (next_state == ACCESS) && (next_cnt == 4'd0);

    assign wr_fire = apb.psel & apb.penable & pready_q & ~pslverr_q & apb.pwrite;
    assign wr_ctrl = wr_fire & (apb.paddr == '0);
    assign wr_cfg  = wr_fire & (apb.paddr != '0) & (apb.paddr < ADDR_W'(NCFG));
    assign wr_pix  = wr_fire & in_range & (apb.paddr >= ADDR_W'(NCFG));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            eng_rdata <= '0;
            start     <= 1'b0;
            done      <= 1'b0;
            ie        <= 1'b0;
            for (int i = 1; i < NCFG; i++)
                cfg[i] <= (i == 1) ? DATA_W'(255) : '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            pready_q  <= fin_d;
            pslverr_q <= fin_d & err_d;
            prdata_q  <= (fin_d && !apb.pwrite && !err_d) ? rd_word(apb.paddr) : '0;
            eng_rdata <= rd_word(eng_addr);
            start     <= wr_ctrl & apb.pwdata[0] & ~eng_busy;
            if (wr_ctrl)
                ie <= apb.pwdata[3];
            // A completion pulse beats a simultaneous clear.
            done <= eng_done | (done & ~(wr_ctrl & apb.pwdata[2]));
            if (wr_cfg)
                cfg[apb.paddr[3:0]] <= apb.pwdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pix)
            pix[apb.paddr[IDX_W-1:0]] <= apb.pwdata;
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign irq         = done & ie;
endmodule

// File: tb/tb_apb_reg_bank.sv
// Scoreboard bench: one bank with three wait states, one with none, shared master.
module tb_apb_reg_bank;
    localparam int DW = 16, AW = 20, DEPTH = 1024;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    apb_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();
    apb_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

    logic          m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pwdata = '0;
    int            tgt = 0;

    assign bus3.psel    = m_psel & (tgt == 0);
    assign bus3.penable = m_penable & (tgt == 0);
    assign bus3.pwrite  = m_pwrite;
    assign bus3.paddr   = m_paddr;
    assign bus3.pwdata  = m_pwdata;
    assign bus0.psel    = m_psel & (tgt == 1);
    assign bus0.penable = m_penable & (tgt == 1);
    assign bus0.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;
    assign bus0.pwdata  = m_pwdata;

    logic          pready_m, perr_m;
    logic [DW-1:0] prdata_m;
    assign pready_m = (tgt == 1) ? bus0.pready  : bus3.pready;
    assign perr_m   = (tgt == 1) ? bus0.pslverr : bus3.pslverr;
    assign prdata_m = (tgt == 1) ? bus0.prdata  : bus3.prdata;

    logic [AW-1:0] eng_addr = '0;
    logic          eng_busy = 1'b0, eng_done = 1'b0;
    logic [DW-1:0] eng_rdata3, eng_rdata0;
    logic          start3, irq3, start0, irq0;
    logic [AW-1:0] eng_addr0 = '0;
    logic          zero = 1'b0;

    apb_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .apb(bus3), .eng_addr(eng_addr), .eng_rdata(eng_rdata3),
        .eng_busy(eng_busy), .eng_done(eng_done), .start(start3), .irq(irq3));

    apb_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .apb(bus0), .eng_addr(eng_addr0), .eng_rdata(eng_rdata0),
        .eng_busy(zero), .eng_done(zero), .start(start0), .irq(irq0));

    // Reference model: register file contents as the bus master sees them.
    logic [DW-1:0] cfg_m [2][1:9];
    logic          ie_m [2], done_m [2];
    logic [DW-1:0] pix_m [2][0:DEPTH-1];
    bit            known [2][0:DEPTH-1];

    typedef struct { logic [DW-1:0] d; logic e; } exp_t;
    exp_t q[$];
    int   nvec = 0, nbad = 0, starts = 0, exp_starts = 0;

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            for (int i = 1; i < 10; i++) cfg_m[t][i] = (i == 1) ? 16'd255 : 16'd0;
            ie_m[t]   = 1'b0;
            done_m[t] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int t, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit done_at_end);
        exp_t e;
        bit   busy;
        int   cyc, ai;
        busy = (t == 0) ? eng_busy : 1'b0;
        ai   = int'(a);
        e.d  = '0;
        e.e  = 1'b0;
        if (a >= DEPTH) e.e = 1'b1;
        else if (w) begin
            if (ai == 0) begin
                ie_m[t] = d[3];
                if (d[2]) done_m[t] = 1'b0;
                if (d[0] && !busy && t == 0) exp_starts++;
            end else if (busy) e.e = 1'b1;
            else if (ai < 10) cfg_m[t][ai] = d;
            else begin
                pix_m[t][ai] = d;
                known[t][ai] = 1'b1;
            end
        end else begin
            if (ai == 0) e.d = {12'b0, ie_m[t], done_m[t], busy, 1'b0};
            else if (ai < 10) e.d = cfg_m[t][ai];
            else e.d = pix_m[t][ai];
        end
        if (done_at_end) done_m[t] = 1'b1;
        @(negedge clk);
        tgt = t; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = w; m_paddr = a; m_pwdata = d;
        q.push_back(e);
        cyc = 1;
        @(negedge clk);
        m_penable = 1'b1;
        cyc = 2;
        while (!pready_m && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        nvec++;
        if (!pready_m) begin
            nbad++;
            $display("FAIL timeout: no pready after %0d cycles at addr %0h", cyc, a);
            q.delete();
        end else if (cyc != ((t == 0) ? 5 : 2)) begin
            nbad++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc, (t == 0) ? 5 : 2);
        end
        if (done_at_end) eng_done = 1'b1;
        @(negedge clk);
        m_psel = 1'b0; m_penable = 1'b0; eng_done = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); eng_done = 1'b1; done_m[0] = 1'b1;
        @(negedge clk); eng_done = 1'b0;
    endtask

    task automatic check_starts(input string name);
        repeat (2) @(negedge clk);
        chk(name, starts, exp_starts);
    endtask

    always @(negedge clk) if (start3) starts++;

    // Monitor: every completing cycle is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (pready_m) begin
                if (q.size() == 0) begin
                    nbad++;
                    $display("FAIL unexpected pready at addr %0h", m_paddr);
                end else begin
                    e = q.pop_front();
                    nvec++;
                    if (prdata_m !== e.d || perr_m !== e.e) begin
                        nbad++;
                        $display("FAIL resp addr %0h: got data %0h err %0b expected data %0h err %0b",
                                 m_paddr, prdata_m, perr_m, e.d, e.e);
                    end
                end
            end else if (prdata_m !== '0 || perr_m !== 1'b0) begin
                nbad++;
                $display("FAIL idle outputs: data %0h err %0b while pready low", prdata_m, perr_m);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;
        int            t, r;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst pready", bus3.pready, 0);
        chk("rst pslverr", bus3.pslverr, 0);
        chk("rst prdata", bus3.prdata, 0);
        chk("rst start", start3, 0);
        chk("rst irq", irq3, 0);
        chk("rst eng_rdata", eng_rdata3, 0);
        chk("rst pready0", bus0.pready, 0);
        rst = 1'b1;
        @(negedge clk);

        // zero wait states
        xfer(1, 0, 20'h1, 0, 0);
        xfer(1, 0, 20'h0, 0, 0);
        xfer(1, 1, 20'hB, 16'hBEEF, 0);
        xfer(1, 0, 20'hB, 0, 0);
        xfer(1, 0, 20'(DEPTH), 0, 0);

        // three wait states, engine port
        xfer(0, 0, 20'h1, 0, 0);
        xfer(0, 1, 20'hA, 16'h1234, 0);
        xfer(0, 0, 20'hA, 0, 0);
        eng_addr = 20'hA;
        @(negedge clk); chk("eng rd 0x0A", eng_rdata3, 16'h1234);
        eng_addr = 20'(DEPTH);
        @(negedge clk); chk("eng rd oor", eng_rdata3, 0);
        eng_addr = 20'h1;
        @(negedge clk); chk("eng rd white", eng_rdata3, 255);

        // start, lock, done, irq
        xfer(0, 1, 20'h0, 16'h0009, 0);
        check_starts("start pulse");
        xfer(0, 0, 20'h0, 0, 0);
        eng_busy = 1'b1;
        xfer(0, 1, 20'h2, 16'h7777, 0);
        xfer(0, 0, 20'h2, 0, 0);
        xfer(0, 1, 20'h0, 16'h0009, 0);
        check_starts("start while busy");
        pulse_done();
        @(negedge clk); chk("irq after done", irq3, 1);
        xfer(0, 0, 20'h0, 0, 0);
        eng_busy = 1'b0;
        xfer(0, 1, 20'h0, 16'h0004, 0);
        @(negedge clk); chk("irq after clear", irq3, 0);
        xfer(0, 0, 20'h0, 0, 0);

        // set beats clear in the same cycle
        xfer(0, 1, 20'h0, 16'h0008, 0);
        pulse_done();
        xfer(0, 1, 20'h0, 16'h000C, 1);
        @(negedge clk); chk("irq set wins", irq3, 1);
        xfer(0, 0, 20'h0, 0, 0);

        // out of range, including aliases of CTRL and 0x0A
        xfer(0, 1, 20'(DEPTH), 16'h0009, 0);
        xfer(0, 0, 20'(DEPTH), 0, 0);
        xfer(0, 1, 20'(DEPTH + 10), 16'hDEAD, 0);
        xfer(0, 0, 20'hA, 0, 0);
        check_starts("no start oor");

        // reset in the middle of a write to 0x05
        @(negedge clk);
        tgt = 0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 20'h5; m_pwdata = 16'hABCD;
        @(negedge clk); m_penable = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid rst pready", bus3.pready, 0);
        chk("mid rst irq", irq3, 0);
        chk("mid rst start", start3, 0);
        chk("mid rst eng_rdata", eng_rdata3, 0);
        @(negedge clk); m_psel = 1'b0; m_penable = 1'b0; rst = 1'b1;
        model_reset();
        @(negedge clk);
        xfer(0, 0, 20'h5, 0, 0);
        xfer(1, 0, 20'h1, 0, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            t = ($urandom % 4 == 0) ? 1 : 0;
            if (t == 0) eng_busy = ($urandom % 4 == 0);
            r = $urandom % 10;
            if (r == 0) a = 20'h0;
            else if (r < 4) a = 20'(1 + $urandom % 9);
            else if (r < 8) a = ($urandom % 8 == 0) ? 20'(DEPTH - 1) : 20'(10 + $urandom % 16);
            else if (r == 8) a = 20'(DEPTH + $urandom % 8);
            else a = 20'($urandom);
            w = $urandom % 2;
            if (!w && a >= 10 && a < DEPTH && !known[t][int'(a)]) w = 1'b1;
            d = 16'($urandom);
            xfer(t, w, a, d, 0);
            if (t == 0 && $urandom % 10 == 0) pulse_done();
        end
        eng_busy = 1'b0;
        check_starts("random starts");
        repeat (2) @(negedge clk);
        chk("queue drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
